alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single integer ALU between two requesters (port 0: execute stage, port 1: address/branch-compare helper).
//  Round-robin arbitration with valid/ready handshakes on request and response sides, one outstanding operation.
//  Drives the ALU control code and operands, registers the result, and returns it to the granted requester.
//  Provides saturating per-port issue counters for performance monitoring.
// PARAMETERS
//  XLEN   32  operand/result width
//  TAG_W  5   requester tag width (e.g. rd index), returned unchanged with the result
//  CNT_W  16  width of each saturating issue counter
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high reset
//  pN_req_valid   in   1       port N (N=0,1) request valid
//  pN_req_ready   out  1       port N request accepted this cycle when valid&ready
//  pN_req_op      in   4       port N ALU control code (0000 ADD .. 1001 SRA)
//  pN_req_a       in   XLEN    port N operand A
//  pN_req_b       in   XLEN    port N operand B
//  pN_req_tag     in   TAG_W   port N tag
//  pN_rsp_valid   out  1       port N response valid
//  pN_rsp_ready   in   1       port N response consumed when valid&ready
//  rsp_result     out  XLEN    registered ALU result (shared by both ports)
//  rsp_zero       out  1       registered (alu_result == 0)
//  rsp_err        out  1       registered illegal-op flag
//  rsp_tag        out  TAG_W   registered tag of the operation
//  alu_control    out  4       control code to ALU
//  alu_a, alu_b   out  XLEN    operands to ALU
//  alu_result     in   XLEN    combinational ALU result, same cycle
//  pN_issue_cnt   out  CNT_W   port N accepted-request count, saturates at all-ones
// BEHAVIOUR
//  - States: EMPTY (no held response), FULL (response held for owner port). Reset -> EMPTY.
//  - slot_free = EMPTY, or FULL with owner's rsp_valid&rsp_ready this cycle (back-to-back allowed).
//  - Grant: if one port valid, it wins; if both valid, port != last_grant wins. last_grant resets to 1 (port 0 first).
//  - pN_req_ready = grant[N] & slot_free; combinational, never high for both ports; low while reset asserted.
//  - Accept cycle: alu_control/alu_a/alu_b = granted request, combinationally; result, zero, tag, err captured
//    at the closing edge; owner <= granted port; last_grant <= granted port; state FULL. Latency 1 cycle.
//  - No accept: alu_control = 0000 (ADD), alu_a = alu_b = 0.
//  - Illegal op (1010..1111): still accepted; ALU driven with ADD; rsp_result = 0, rsp_zero = 1, rsp_err = 1.
//  - pN_rsp_valid = FULL & (owner == N). rsp_* stable while valid and not consumed.
//  - Consume without new accept: state -> EMPTY; rsp_* hold last values.
//  - Consume + accept same cycle: new response replaces old at that edge, no bubble.
//  - Request fields may change while not ready; only the accept-cycle values matter.
//  - Issue counter N increments on each port N accept; holds at 2^CNT_W-1.
//  - Reset (any time, incl. mid-operation): state EMPTY, held response dropped, all rsp_* = 0,
//    all rsp_valid = 0, counters = 0, last_grant = 1. Outputs settle without a clock edge.
// TESTING
//  - p0 valid op=0000 a=5 b=7 tag=3 -> ready same cycle; next cycle p0_rsp_valid, result=12, zero=0, tag=3.
//  - p0,p1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; one accept per cycle; counters 2,2 after 4 cycles.
//  - p1 op=0001 a=9 b=9, p1_rsp_ready=0 for 5 cycles -> result=0, zero=1 held stable; no req_ready on either port.
//  - p0 op=1100 a=1 b=2 -> alu_control=0000 on accept; rsp_err=1, result=0, zero=1.
//  - reset pulse while FULL -> rsp_valid drops asynchronously; after release, p0 wins first contended grant.
//  - CNT_W=2 build, 5 p0 accepts -> p0_issue_cnt = 3 (saturated).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one integer ALU between two requesters
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic [3:0]       p0_req_op,
    input  logic [XLEN-1:0]  p0_req_a,
    input  logic [XLEN-1:0]  p0_req_b,
    input  logic [TAG_W-1:0] p0_req_tag,
    output logic             p0_rsp_valid,
    input  logic             p0_rsp_ready,
    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic [3:0]       p1_req_op,
    input  logic [XLEN-1:0]  p1_req_a,
    input  logic [XLEN-1:0]  p1_req_b,
    input  logic [TAG_W-1:0] p1_req_tag,
    output logic             p1_rsp_valid,
    input  logic             p1_rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       alu_control,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result,
    output logic [CNT_W-1:0] p0_issue_cnt,
    output logic [CNT_W-1:0] p1_issue_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic               owner;
    logic               last_grant;
    logic               consume;
    logic               slot_free;
    logic               gnt0, gnt1;
    logic               accept;
    logic               gport;
    logic               illegal;
    logic [3:0]         g_op;
    logic [XLEN-1:0]    g_a, g_b;
    logic [TAG_W-1:0]   g_tag;

    // The held response frees the slot in the same cycle it is consumed, so issue can be back-to-back.
    always_comb begin
        consume      = (state == FULL) && (owner ? p1_rsp_ready : p0_rsp_ready);
        slot_free    = (state == EMPTY) || consume;
        gnt0         = p0_req_valid && (!p1_req_valid || last_grant);
        gnt1         = p1_req_valid && (!p0_req_valid || !last_grant);
        p0_req_ready = gnt0 && slot_free && !reset;
        p1_req_ready = gnt1 && slot_free && !reset;
        accept       = p0_req_ready || p1_req_ready;
        gport        = p1_req_ready;
        g_op         = gport ? p1_req_op  : p0_req_op;
        g_a          = gport ? p1_req_a   : p0_req_a;
        g_b          = gport ? p1_req_b   : p0_req_b;
        g_tag        = gport ? p1_req_tag : p0_req_tag;
        illegal      = (g_op > 4'd9);
    end

    always_comb begin
        alu_control = 4'd0;
        alu_a       = '0;
        alu_b       = '0;
        if (accept) begin
            alu_control = illegal ? 4'd0 : g_op;
            alu_a       = g_a;
            alu_b       = g_b;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if (consume) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign p0_rsp_valid = (state == FULL) && !owner;
    assign p1_rsp_valid = (state == FULL) && owner;

    // Response registers keep their last values after consumption until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else if (accept) begin
            owner      <= gport;
            last_grant <= gport;
            rsp_result <= illegal ? '0 : alu_result;
            rsp_zero   <= illegal ? 1'b1 : (alu_result == '0);
            rsp_err    <= illegal;
            rsp_tag    <= g_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_issue_cnt <= '0;
            p1_issue_cnt <= '0;
        end else begin
            if (p0_req_ready && (p0_issue_cnt != CNT_MAX)) begin
                p0_issue_cnt <= p0_issue_cnt + CNT_ONE;
            end
            if (p1_req_ready && (p1_issue_cnt != CNT_MAX)) begin
                p1_issue_cnt <= p1_issue_cnt + CNT_ONE;
            end
        end
    end

endmodule
